csr_sequencer: RTL

Sequencing controller for the CSR register file. It accepts CSR instructions from the core pipeline and plain read/write accesses from the host/debug port, and arbitrates between the two round-robin. Each granted access runs as a fixed read-modify-write sequence against the single-ported CSR file, and the old CSR value is returned to the requester. It sits between the decode/execute stage, the host interface and the CSR storage.

---
 rtl/csr_pkg.sv | 30 +++
 rtl/csr_rr_arbiter.sv | 28 ++
 rtl/csr_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared types and defaults for the CSR read-modify-write sequencer.
package csr_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic [1:0] {
    RW = 2'd0,
    RS = 2'd1,
    RC = 2'd2
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    MODIFY = 2'd2,
    RESP   = 2'd3
  } seq_state_e;

  typedef enum logic {
    CORE = 1'b0,
    HOST = 1'b1
  } req_id_e;

  // Encoding 2'b11 is reserved and behaves as a plain write.
  function automatic csr_op_e decode_op(input logic [1:0] raw);
    return (raw == 2'b11) ? RW : csr_op_e'(raw);
  endfunction

endpackage

// File: rtl/csr_rr_arbiter.sv
// Two-input round-robin grant; the requester not served last wins a tie.
module csr_rr_arbiter
  import csr_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_core_vld,
  input  logic i_host_vld,
  output logic o_gnt_core,
  output logic o_gnt_host
);

  req_id_e r_last;
  logic    w_pick_core;

  assign w_pick_core = i_core_vld && (!i_host_vld || (r_last == HOST));
  assign o_gnt_core  = i_en && w_pick_core;
  assign o_gnt_host  = i_en && i_host_vld && !w_pick_core;

  // A grant is always taken, so the history only moves on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_last <= HOST;
    else if (o_gnt_core) r_last <= CORE;
    else if (o_gnt_host) r_last <= HOST;
  end

endmodule

// File: rtl/csr_sequencer.sv
// Arbitrates core CSR instructions and host accesses, runs each as a
// fixed read-modify-write on the single-ported CSR file, returns old value.
module csr_sequencer
  import csr_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [1:0]        core_op,
  input  logic              core_use_imm,
  input  logic              core_rs1_is_x0,
  input  logic [XLEN-1:0]   core_rs1_val,
  input  logic [4:0]        core_zimm,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_rsp_valid,
  output logic [XLEN-1:0]   core_rsp_rdata,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [XLEN-1:0]   host_wdata,
  output logic              host_rsp_valid,
  output logic [XLEN-1:0]   host_rsp_rdata,
  output logic              csr_ren,
  output logic [ADDR_W-1:0] csr_raddr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              csr_wen,
  output logic [ADDR_W-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata
);

  seq_state_e        r_state;
  req_id_e           r_id;
  csr_op_e           r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_operand;
  logic              r_wr_en;
  logic [XLEN-1:0]   r_core_rdata;
  logic [XLEN-1:0]   r_host_rdata;

  logic            w_gnt_core;
  logic            w_gnt_host;
  logic            w_core_null;
  csr_op_e         w_core_op;
  logic [XLEN-1:0] w_core_opnd;
  logic [XLEN-1:0] w_new;
  logic            w_wen;

  // Ready must read low while reset is held, even with a request pending.
  csr_rr_arbiter u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       ((r_state == IDLE) && rst_n),
    .i_core_vld (core_req_valid),
    .i_host_vld (host_req_valid),
    .o_gnt_core (w_gnt_core),
    .o_gnt_host (w_gnt_host)
  );

  assign core_req_ready = w_gnt_core;
  assign host_req_ready = w_gnt_host;

  assign w_core_op   = decode_op(core_op);
  assign w_core_opnd = core_use_imm ? {{(XLEN-5){1'b0}}, core_zimm} : core_rs1_val;
  assign w_core_null = core_use_imm ? (core_zimm == 5'd0) : core_rs1_is_x0;

  always_comb begin
    w_new = r_operand;
    unique case (r_op)
      RS:      w_new = csr_rdata | r_operand;
      RC:      w_new = csr_rdata & ~r_operand;
      default: w_new = r_operand;
    endcase
  end

  assign w_wen     = (r_state == MODIFY) && r_wr_en;
  assign csr_ren   = (r_state == READ);
  assign csr_raddr = csr_ren ? r_addr : '0;
  assign csr_wen   = w_wen;
  assign csr_waddr = w_wen ? r_addr : '0;
  assign csr_wdata = w_wen ? w_new  : '0;

  assign core_rsp_valid = (r_state == RESP) && (r_id == CORE);
  assign host_rsp_valid = (r_state == RESP) && (r_id == HOST);
  assign core_rsp_rdata = r_core_rdata;
  assign host_rsp_rdata = r_host_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_id         <= CORE;
      r_op         <= RW;
      r_addr       <= '0;
      r_operand    <= '0;
      r_wr_en      <= 1'b0;
      r_core_rdata <= '0;
      r_host_rdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_gnt_host) begin
            r_state   <= READ;
            r_id      <= HOST;
            r_op      <= RW;
            r_addr    <= host_addr;
            r_operand <= host_wdata;
            r_wr_en   <= host_we;
          end else if (w_gnt_core) begin
            r_state   <= READ;
            r_id      <= CORE;
            r_op      <= w_core_op;
            r_addr    <= core_addr;
            r_operand <= w_core_opnd;
            // Set/clear with a null source must not touch the CSR.
            r_wr_en   <= (w_core_op == RW) || !w_core_null;
          end
        end
        READ:   r_state <= MODIFY;
        MODIFY: begin
          // Per-requester copies so each rsp_rdata holds until its own next response.
          if (r_id == CORE) r_core_rdata <= csr_rdata;
          else              r_host_rdata <= csr_rdata;
          r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
